// File: rtl/dpd_fb_delay_meas.sv
`default_nettype none
// ============================================================================
// Module      : dpd_fb_delay_meas
// Description : Feedback-path loop-delay estimator for DPD adaptation.
//               Counts samples from a start trigger until the returning
//               burst magnitude (|i|+|q|) stays at or above a threshold for
//               HOLD consecutive samples. Reports the onset sample index as
//               the measured delay, or a timeout if no onset qualifies within
//               MAX_DELAY. Also forwards the feedback samples with one
//               register stage.
//               Optional feature macro: DPD_FB_PEAK_EN (peak magnitude
//               tracking over the search window; peak_mag is 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module dpd_fb_delay_meas #(
  parameter int W         = 20,
  parameter int MAX_DELAY = 255,
  parameter int HOLD      = 4,
  parameter int DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W:0]    thr,
  input  logic [W-1:0]  sig_pa_i,
  input  logic [W-1:0]  sig_pa_q,
  output logic [W-1:0]  fb_i,
  output logic [W-1:0]  fb_q,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [DW-1:0] delay,
  output logic          delay_valid,
  output logic [W:0]    peak_mag
);

  // Index of the last sample that can still complete a qualifying run.
  localparam int c_LAST = MAX_DELAY + HOLD - 1;
  localparam int c_NW   = $clog2(c_LAST + 1);
  localparam int c_RW   = $clog2(HOLD + 1);

  localparam logic [c_NW-1:0] c_LAST_N  = c_NW'(c_LAST);
  localparam logic [c_NW-1:0] c_HOLD_M1 = c_NW'(HOLD - 1);
  localparam logic [c_RW-1:0] c_HOLD_R  = c_RW'(HOLD);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEARCH    = 2'd1,
    S_REPORT_OK = 2'd2,
    S_REPORT_TO = 2'd3
  } state_t;

  state_t          r_state;
  logic [c_NW-1:0] r_n;
  logic [c_RW-1:0] r_run;
  logic            r_above;
  logic            r_busy;
  logic            r_done;
  logic            r_timeout;
  logic [DW-1:0]   r_delay;
  logic            r_delay_valid;
  logic [W-1:0]    r_fb_i;
  logic [W-1:0]    r_fb_q;

  logic [W:0]      w_ext_i;
  logic [W:0]      w_ext_q;
  logic [W:0]      w_abs_i;
  logic [W:0]      w_abs_q;
  logic [W:0]      w_mag;
  logic [c_RW-1:0] w_run_next;

  // Sign-extend to W+1 bits before negating so -2^(W-1) maps to +2^(W-1);
  // the sum of two such magnitudes (at most 2^W) still fits in W+1 bits.
  assign w_ext_i = {sig_pa_i[W-1], sig_pa_i};
  assign w_ext_q = {sig_pa_q[W-1], sig_pa_q};
  assign w_abs_i = sig_pa_i[W-1] ? (~w_ext_i + 1'b1) : w_ext_i;
  assign w_abs_q = sig_pa_q[W-1] ? (~w_ext_q + 1'b1) : w_ext_q;
  assign w_mag   = w_abs_i + w_abs_q;

  // Run length after the sample currently being processed.
  assign w_run_next = r_above ? (r_run + 1'b1) : '0;

  // Feedback forwarding: plain one-cycle register, independent of the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fb_i <= '0;
      r_fb_q <= '0;
    end else begin
      r_fb_i <= sig_pa_i;
      r_fb_q <= sig_pa_q;
    end
  end

  // Threshold compare registered so sample n is processed one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_above <= 1'b0;
    end else begin
      r_above <= (w_mag >= thr);
    end
  end

  // Measurement FSM: search for a sustained onset and report the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_n           <= '0;
      r_run         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_delay       <= '0;
      r_delay_valid <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_n   <= '0;
          r_run <= '0;
          if (start) begin
            r_state <= S_SEARCH;
            r_busy  <= 1'b1;
          end
        end
        S_SEARCH: begin
          r_run <= w_run_next;
          r_n   <= r_n + 1'b1;
          if (w_run_next == c_HOLD_R) begin
            // Onset is the first sample of the qualifying run.
            r_state       <= S_REPORT_OK;
            r_done        <= 1'b1;
            r_delay       <= DW'(r_n - c_HOLD_M1);
            r_delay_valid <= 1'b1;
          end else if (r_n == c_LAST_N) begin
            r_state       <= S_REPORT_TO;
            r_timeout     <= 1'b1;
            r_delay_valid <= 1'b0;
          end
        end
        S_REPORT_OK, S_REPORT_TO: begin
          // Report cycle: still busy, so a start here is ignored.
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DPD_FB_PEAK_EN
  logic [W:0] r_mag;
  logic [W:0] r_peak;

  // Magnitude registered alongside the above flag so both describe sample n.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mag <= '0;
    end else begin
      r_mag <= w_mag;
    end
  end

  // Running maximum over the searched samples; cleared on an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_peak <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_peak <= '0;
    end else if ((r_state == S_SEARCH) && (r_mag > r_peak)) begin
      r_peak <= r_mag;
    end
  end

  assign peak_mag = r_peak;
`else
  assign peak_mag = '0;
`endif

  assign fb_i        = r_fb_i;
  assign fb_q        = r_fb_q;
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign delay       = r_delay;
  assign delay_valid = r_delay_valid;

endmodule
`default_nettype wire

// File: tb/tb_dpd_fb_delay_meas.sv
`default_nettype none
// ============================================================================
// Module      : tb_dpd_fb_delay_meas
// Description : Self-checking bench for dpd_fb_delay_meas. Stimulus is a
//               per-sample table; expected results come from a sample-indexed
//               reference model (magnitude, run length, first qualifying run).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dpd_fb_delay_meas;

  localparam int W         = 20;
  localparam int MAX_DELAY = 255;
  localparam int HOLD      = 4;
  localparam int DW        = $clog2(MAX_DELAY + 1);
  localparam int LAST_N    = MAX_DELAY + HOLD - 1;
  localparam int WIN       = LAST_N + 8;
`ifdef DPD_FB_PEAK_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          start;
  logic [W:0]    thr;
  logic [W-1:0]  sig_pa_i;
  logic [W-1:0]  sig_pa_q;
  logic [W-1:0]  fb_i;
  logic [W-1:0]  fb_q;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [DW-1:0] delay;
  logic          delay_valid;
  logic [W:0]    peak_mag;

  dpd_fb_delay_meas #(
    .W(W), .MAX_DELAY(MAX_DELAY), .HOLD(HOLD), .DW(DW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .thr(thr),
    .sig_pa_i(sig_pa_i), .sig_pa_q(sig_pa_q),
    .fb_i(fb_i), .fb_q(fb_q), .busy(busy), .done(done), .timeout(timeout),
    .delay(delay), .delay_valid(delay_valid), .peak_mag(peak_mag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   tot;
  int   bad;
  int   stim_i [0:511];
  int   stim_q [0:511];
  int   thr_v;
  int   last_delay;
  logic busy_seen [0:511];

  // Results of one measurement as seen on the DUT ports
  int         m_pulse_cyc;
  bit         m_pulse_ok;
  int         m_ndone;
  int         m_nto;
  logic [DW-1:0] m_delay;
  logic       m_dv;
  logic [W:0] m_peak;

  // Reference model results
  bit         e_ok;
  int         e_term;
  int         e_delay;
  int         e_dv;
  logic [W:0] e_peak;

  function automatic longint iabs(input int v);
    return (v < 0) ? -longint'(v) : longint'(v);
  endfunction

  task automatic stim_clear();
    for (int n = 0; n < 512; n++) begin
      stim_i[n] = 0;
      stim_q[n] = 0;
    end
  endtask

  task automatic stim_fill(input int from_n, input int to_n, input int iv, input int qv);
    for (int n = from_n; n <= to_n; n++) begin
      stim_i[n] = iv;
      stim_q[n] = qv;
    end
  endtask

  // Behavioural model: walk samples n = 0.. and find the first HOLD-long run.
  task automatic model_run();
    int     run;
    longint mx;
    longint m;
    run    = 0;
    mx     = 0;
    e_ok   = 1'b0;
    e_term = LAST_N;
    for (int n = 0; n <= LAST_N; n++) begin
      m = iabs(stim_i[n]) + iabs(stim_q[n]);
      if (m > mx) mx = m;
      run = (m >= longint'(thr_v)) ? run + 1 : 0;
      if (run == HOLD) begin
        e_ok   = 1'b1;
        e_term = n;
        break;
      end
    end
    e_delay = e_ok ? (e_term - HOLD + 1) : last_delay;
    e_dv    = e_ok ? 1 : 0;
    e_peak  = PEAK_ON ? (W+1)'(mx) : '0;
  endtask

  // Drive one measurement. Caller is #1 after a rising edge (cycle c0).
  task automatic measure(input int rep_a, input int rep_b, input int rst_at, input bit early);
    m_pulse_cyc = -1;
    m_pulse_ok  = 1'b0;
    m_ndone     = 0;
    m_nto       = 0;
    m_delay     = 'x;
    m_dv        = 1'bx;
    m_peak      = 'x;
    for (int k = 0; k < 512; k++) busy_seen[k] = 1'bx;
    thr      = (W+1)'(thr_v);
    start    = 1'b1;
    sig_pa_i = W'(stim_i[0]);
    sig_pa_q = W'(stim_q[0]);
    for (int k = 1; k <= WIN; k++) begin
      @(posedge clk); #1;
      busy_seen[k] = busy;
      if (done === 1'b1) begin
        m_ndone++;
        if (m_pulse_cyc < 0) begin
          m_pulse_cyc = k; m_pulse_ok = 1'b1;
          m_delay = delay; m_dv = delay_valid; m_peak = peak_mag;
        end
      end
      if (timeout === 1'b1) begin
        m_nto++;
        if (m_pulse_cyc < 0) begin
          m_pulse_cyc = k; m_pulse_ok = 1'b0;
          m_delay = delay; m_dv = delay_valid; m_peak = peak_mag;
        end
      end
      if (early && m_pulse_cyc >= 0 && k == m_pulse_cyc + 1) break;
      start    = (k == rep_a) || (k == rep_b);
      reset    = (k == rst_at);
      sig_pa_i = W'(stim_i[k]);
      sig_pa_q = W'(stim_q[k]);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      start    = 1'($urandom_range(0, 1));
      sig_pa_i = W'($urandom);
      sig_pa_q = W'($urandom);
      thr      = (W+1)'($urandom);
      @(posedge clk); #1;
    end
    tot++; if (fb_i !== '0) begin bad++; $display("FAIL reset_fb_i: got %0h want 0", fb_i); end
    tot++; if (fb_q !== '0) begin bad++; $display("FAIL reset_fb_q: got %0h want 0", fb_q); end
    tot++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    tot++; if (done !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL reset_pulses: got done=%b timeout=%b want 0", done, timeout); end
    tot++; if (delay !== '0 || delay_valid !== 1'b0) begin bad++; $display("FAIL reset_delay: got %0d/%b want 0/0", delay, delay_valid); end
    tot++; if (peak_mag !== '0) begin bad++; $display("FAIL reset_peak: got %0d want 0", peak_mag); end
    reset    = 1'b0;
    start    = 1'b0;
    sig_pa_i = '0;
    sig_pa_q = '0;
    @(posedge clk); #1;
    tot++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_dominates_start: busy=%b want 0", busy); end
    last_delay = 0;
  endtask

  task automatic test_normal_onset();
    stim_clear();
    stim_fill(41, 511, 30000, 20000);
    thr_v = 10000;
    model_run();
    measure(-1, -1, -1, 1'b0);
    tot++; if (m_pulse_cyc !== 46 || !m_pulse_ok) begin bad++; $display("FAIL normal_done_cycle: got %0d ok=%b want 46", m_pulse_cyc, m_pulse_ok); end
    tot++; if (m_ndone !== 1 || m_nto !== 0) begin bad++; $display("FAIL normal_pulse_count: got done=%0d to=%0d want 1/0", m_ndone, m_nto); end
    tot++; if (m_delay !== DW'(41) || m_dv !== 1'b1) begin bad++; $display("FAIL normal_delay: got %0d/%b want 41/1", m_delay, m_dv); end
    tot++; if (m_peak !== (PEAK_ON ? 21'd50000 : 21'd0)) begin bad++; $display("FAIL normal_peak: got %0d want %0d", m_peak, PEAK_ON ? 50000 : 0); end
    for (int k = 1; k <= 46; k++) begin
      tot++; if (busy_seen[k] !== 1'b1) begin bad++; $display("FAIL normal_busy_c%0d: got %b want 1", k, busy_seen[k]); end
    end
    tot++; if (busy_seen[47] !== 1'b0) begin bad++; $display("FAIL normal_busy_end: got %b want 0", busy_seen[47]); end
    last_delay = 41;
  endtask

  task automatic test_timeout();
    stim_clear();
    thr_v = 10000;
    model_run();
    measure(-1, -1, -1, 1'b0);
    tot++; if (m_pulse_cyc !== 260 || m_pulse_ok) begin bad++; $display("FAIL timeout_cycle: got %0d ok=%b want 260 timeout", m_pulse_cyc, m_pulse_ok); end
    tot++; if (m_ndone !== 0 || m_nto !== 1) begin bad++; $display("FAIL timeout_pulse_count: got done=%0d to=%0d want 0/1", m_ndone, m_nto); end
    tot++; if (m_delay !== DW'(41) || m_dv !== 1'b0) begin bad++; $display("FAIL timeout_delay: got %0d/%b want 41/0", m_delay, m_dv); end
    tot++; if (m_peak !== '0) begin bad++; $display("FAIL timeout_peak: got %0d want 0", m_peak); end
    tot++; if (busy_seen[260] !== 1'b1 || busy_seen[261] !== 1'b0) begin bad++; $display("FAIL timeout_busy: got %b%b want 10", busy_seen[260], busy_seen[261]); end
  endtask

  task automatic test_glitch();
    stim_clear();
    stim_fill(10, 11, 30000, 20000);
    stim_fill(60, 511, -25000, 15000);
    thr_v = 10000;
    model_run();
    measure(-1, -1, -1, 1'b0);
    tot++; if (m_pulse_cyc !== 65 || !m_pulse_ok) begin bad++; $display("FAIL glitch_done_cycle: got %0d ok=%b want 65", m_pulse_cyc, m_pulse_ok); end
    tot++; if (m_ndone !== 1 || m_nto !== 0) begin bad++; $display("FAIL glitch_pulse_count: got done=%0d to=%0d want 1/0", m_ndone, m_nto); end
    tot++; if (m_delay !== DW'(60) || m_dv !== 1'b1) begin bad++; $display("FAIL glitch_delay: got %0d/%b want 60/1", m_delay, m_dv); end
    tot++; if (m_peak !== e_peak) begin bad++; $display("FAIL glitch_peak: got %0d want %0d", m_peak, e_peak); end
    last_delay = 60;
  endtask

  task automatic test_handshake();
    // Re-pulse start mid-search and in the done cycle: both must be ignored.
    stim_clear();
    stim_fill(41, 511, 30000, 20000);
    thr_v = 10000;
    model_run();
    measure(5, 46, -1, 1'b0);
    tot++; if (m_ndone !== 1 || m_nto !== 0) begin bad++; $display("FAIL hs_single_done: got done=%0d to=%0d want 1/0", m_ndone, m_nto); end
    tot++; if (m_pulse_cyc !== 46 || m_delay !== DW'(41)) begin bad++; $display("FAIL hs_result: got cyc=%0d delay=%0d want 46/41", m_pulse_cyc, m_delay); end
    tot++; if (busy_seen[47] !== 1'b0) begin bad++; $display("FAIL hs_start_in_done_cycle: busy=%b want 0", busy_seen[47]); end
    // Reset in the middle of the search aborts without any pulse.
    measure(-1, -1, 20, 1'b0);
    tot++; if (m_ndone !== 0 || m_nto !== 0) begin bad++; $display("FAIL hs_abort_pulses: got done=%0d to=%0d want 0/0", m_ndone, m_nto); end
    tot++; if (busy_seen[20] !== 1'b1 || busy_seen[21] !== 1'b0) begin bad++; $display("FAIL hs_abort_busy: got %b%b want 10", busy_seen[20], busy_seen[21]); end
    tot++; if (delay !== '0 || delay_valid !== 1'b0) begin bad++; $display("FAIL hs_abort_delay: got %0d/%b want 0/0", delay, delay_valid); end
    last_delay = 0;
    stim_clear();
    stim_fill(17, 511, 9000, -1500);
    thr_v = 10000;
    model_run();
    measure(-1, -1, -1, 1'b0);
    tot++; if (m_pulse_cyc !== 22 || m_delay !== DW'(17) || m_dv !== 1'b1) begin bad++; $display("FAIL hs_after_reset: got cyc=%0d delay=%0d dv=%b want 22/17/1", m_pulse_cyc, m_delay, m_dv); end
    last_delay = 17;
  endtask

  task automatic test_full_scale();
    logic [W-1:0] pi;
    logic [W-1:0] pq;
    stim_clear();
    stim_fill(5, 511, -524288, -524288);
    thr_v = 1048576;
    model_run();
    measure(-1, -1, -1, 1'b0);
    tot++; if (m_pulse_cyc !== 10 || m_delay !== DW'(5) || m_dv !== 1'b1) begin bad++; $display("FAIL fs_result: got cyc=%0d delay=%0d dv=%b want 10/5/1", m_pulse_cyc, m_delay, m_dv); end
    tot++; if (m_peak !== (PEAK_ON ? 21'd1048576 : 21'd0)) begin bad++; $display("FAIL fs_peak: got %0d want %0d", m_peak, PEAK_ON ? 1048576 : 0); end
    last_delay = 5;
    // Feedback forwarding latency with extreme and random codes.
    pi = 20'h80000;
    pq = 20'h80000;
    sig_pa_i = pi;
    sig_pa_q = pq;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      tot++; if (fb_i !== pi || fb_q !== pq) begin bad++; $display("FAIL fs_fb_c%0d: got %0h/%0h want %0h/%0h", c, fb_i, fb_q, pi, pq); end
      pi = (c == 0) ? 20'h7FFFF : W'($urandom);
      pq = W'($urandom);
      sig_pa_i = pi;
      sig_pa_q = pq;
    end
  endtask

  task automatic test_back_to_back();
    int first_end;
    stim_clear();
    stim_fill(3, 511, 12000, 0);
    thr_v = 10000;
    model_run();
    measure(-1, -1, -1, 1'b1);
    first_end = m_pulse_cyc;
    tot++; if (m_pulse_cyc !== 8 || m_delay !== DW'(3)) begin bad++; $display("FAIL b2b_first: got cyc=%0d delay=%0d want 8/3", m_pulse_cyc, m_delay); end
    tot++; if (busy_seen[9] !== 1'b0) begin bad++; $display("FAIL b2b_first_busy: got %b want 0", busy_seen[9]); end
    last_delay = 3;
    stim_clear();
    stim_fill(7, 511, 0, -11000);
    model_run();
    measure(-1, -1, -1, 1'b1);
    tot++; if (m_pulse_cyc !== 12 || m_delay !== DW'(7) || m_dv !== 1'b1) begin bad++; $display("FAIL b2b_second: got cyc=%0d delay=%0d dv=%b want 12/7/1 (first end %0d)", m_pulse_cyc, m_delay, m_dv, first_end); end
    last_delay = 7;
  endtask

  task automatic gen_random();
    int onset;
    int a;
    thr_v = int'($urandom_range(1000, 1000000));
    onset = int'($urandom_range(0, MAX_DELAY + 30));
    for (int n = 0; n < 512; n++) begin
      if ((n >= onset && $urandom_range(0, 9) != 0) || (n < onset && $urandom_range(0, 7) == 0)) begin
        a = int'($urandom_range(thr_v / 2 + 1, 524287));
        stim_i[n] = $urandom_range(0, 1) ? -a : a;
        a = int'($urandom_range(thr_v / 2 + 1, 524287));
        stim_q[n] = $urandom_range(0, 1) ? -a : a;
      end else begin
        a = int'($urandom_range(0, thr_v / 4));
        stim_i[n] = $urandom_range(0, 1) ? -a : a;
        a = int'($urandom_range(0, thr_v / 4));
        stim_q[n] = $urandom_range(0, 1) ? -a : a;
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      gen_random();
      model_run();
      measure(-1, -1, -1, it[0]);
      tot++; if (m_pulse_ok !== e_ok || m_pulse_cyc !== e_term + 2) begin bad++; $display("FAIL rand%0d_pulse: got ok=%b cyc=%0d want ok=%b cyc=%0d", it, m_pulse_ok, m_pulse_cyc, e_ok, e_term + 2); end
      tot++; if (m_ndone + m_nto !== 1) begin bad++; $display("FAIL rand%0d_count: got done=%0d to=%0d want one pulse", it, m_ndone, m_nto); end
      tot++; if (m_delay !== DW'(e_delay) || m_dv !== 1'(e_dv)) begin bad++; $display("FAIL rand%0d_delay: got %0d/%b want %0d/%0d", it, m_delay, m_dv, e_delay, e_dv); end
      tot++; if (m_peak !== e_peak) begin bad++; $display("FAIL rand%0d_peak: got %0d want %0d", it, m_peak, e_peak); end
      tot++; if (busy_seen[e_term + 2] !== 1'b1 || busy_seen[e_term + 3] !== 1'b0) begin bad++; $display("FAIL rand%0d_busy: got %b%b want 10", it, busy_seen[e_term + 2], busy_seen[e_term + 3]); end
      last_delay = e_delay;
    end
  endtask

  initial begin
    tot        = 0;
    bad        = 0;
    last_delay = 0;
    reset      = 1'b1;
    start      = 1'b0;
    thr        = '0;
    sig_pa_i   = '0;
    sig_pa_q   = '0;
    test_reset();
    test_normal_onset();
    test_timeout();
    test_glitch();
    test_handshake();
    test_full_scale();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
`default_nettype wire
